// File: rtl/print_request_arbiter.sv
// rtl/print_request_arbiter.sv - fixed-priority arbiter sharing one message-print engine among edge-triggered sources
// Optional stuck-engine abort timer: define PRINT_TIMEOUT_EN.
module print_request_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             eng_busy,
  input  logic             eng_done,
  input  logic             clr_lost,
  output logic             eng_start,
  output logic [ID_W-1:0]  msg_id,
  output logic             active,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] lost,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] sel_oh;
  logic [N_REQ-1:0] clr_vec;
  logic [ID_W-1:0]  sel_id;
  logic             grant;
  logic             expire;

  if ((2 ** ID_W) < N_REQ) begin : g_bad_id_w
    $error("ID_W too narrow to encode N_REQ sources");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign rise = req & ~req_q;

  // Isolate the lowest set pending bit: bit 0 is the highest priority source.
  assign sel_oh = pending & (~pending + N_REQ'(1));

  always_comb begin
    sel_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i]) sel_id = ID_W'(i);
    end
  end

  assign grant   = (state == IDLE) && (|pending) && !eng_busy;
  assign clr_vec = grant ? sel_oh : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (grant) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT: begin
        if (eng_done)    state_nxt = IDLE;
        else if (expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign eng_start = (state == START);
  assign active    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      pending <= '0;
      lost    <= '0;
      msg_id  <= '0;
    end else begin
      state   <= state_nxt;
      req_q   <= req;
      // A rise wins over a same-cycle grant clear; only a rise on an already waiting bit counts as lost.
      pending <= (pending & ~clr_vec) | rise;
      lost    <= (clr_lost ? '0 : lost) | (rise & pending & ~clr_vec);
      if (grant) msg_id <= sel_id;
    end
  end

`ifdef PRINT_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] timer;

  // Abort at the end of the TIMEOUT-th WAIT cycle without done.
  assign expire = (timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= (state == WAIT) && !eng_done && expire;
      if (state == START) timer <= '0;
      else if ((state == WAIT) && !eng_done) timer <= timer + TMR_W'(1);
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/print_request_arbiter.md
Name: print_request_arbiter

Overview:
- Shares the single message-print engine (text/UART output) between N_REQ level-type event sources, such as switch change, alarm and sensor out-of-range.
- Each source's rising edge becomes one pending print request.
- A fixed-priority scheduler issues one-cycle start pulses with a message ID to the engine and waits for its done handshake before granting again.
- Sits between the event-detect logic and the print engine. It replaces per-source one-shot pulse generators.

Parameters:
- N_REQ, 4, number of requesting sources. Bit 0 has the highest priority (alarm).
- ID_W, 2, width of msg_id. Must satisfy 2**ID_W >= N_REQ.
- TIMEOUT, 1023, cycles to wait for done before aborting a grant (used only with PRINT_TIMEOUT_EN).

Ports:
- clk, in, 1: system clock. All logic is on the rising edge.
- rst, in, 1: synchronous reset, active-high.
- req, in, N_REQ: level request per source. Each 0→1 transition is one print event.
- eng_busy, in, 1: the print engine is occupied. No start is issued while it is high.
- eng_done, in, 1: one-cycle pulse from the engine when the current message has finished.
- eng_start, out, 1: one-cycle pulse that launches the engine.
- msg_id, out, ID_W: index of the granted source. Stable from the start cycle until the grant ends.
- active, out, 1: high while a grant is outstanding (states START and WAIT).
- pending, out, N_REQ: latched un-served requests.
- lost, out, N_REQ: sticky flag per source. Set when a new edge arrives while that source is already pending.
- clr_lost, in, 1: clears all lost bits.
- timeout, out, 1: one-cycle pulse when a grant is aborted (always 0 without the optional feature).

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE; req_q, pending, lost, msg_id and the timer are all 0.
  - eng_start, active and timeout are all 0.
  - Because req_q resets to 0, a req held high through reset produces one request after reset.
  - Reset mid-grant drops the grant and all pending requests. No start is emitted.
- Edge detect:
  - rise[i] = req[i] & ~req_q[i]; req_q <= req every cycle.
  - rise[i] sets pending[i] next cycle.
  - If pending[i] is already 1 and is not being cleared that cycle, lost[i] <= 1.
  - clr_lost has lower priority than a simultaneous new loss (the set wins).
- Selection: the lowest-index set bit of pending. Fixed priority, no fairness.
- State machine (registered state, Moore outputs):
  - IDLE: if pending is non-zero and eng_busy=0 → START. In the same cycle, latch msg_id = selected index and clear that pending bit.
  - START: eng_start=1 and active=1 for exactly this cycle. Then → WAIT unconditionally.
  - WAIT: active=1. On eng_done=1 → IDLE. The earliest next START is 2 cycles after done.
- Clear/set collision: a rise on index i in the same cycle its pending bit is cleared leaves pending[i]=1 (the set wins). lost is not set in this case.
- eng_done arriving in IDLE or START is ignored.
- Latency: rise sampled at cycle t → pending at t+1 → eng_start high at t+2, given eng_busy=0 and the arbiter is idle.
- eng_busy is checked only in IDLE. Once in START, the start pulse is not withdrawn.
- msg_id holds its value after returning to IDLE until the next grant.

Optional Feature:
- Macro: PRINT_TIMEOUT_EN.
- Defined:
  - A ceil(log2(TIMEOUT+1))-bit timer clears on entry to WAIT and increments each WAIT cycle without done.
  - When it reaches TIMEOUT with no done → IDLE, with a timeout pulse of one cycle coincident with the return.
  - The aborted request is not re-queued.
  - Done in the same cycle as expiry is treated as normal completion, with timeout=0.
- Not defined: WAIT persists until eng_done. timeout is tied to 0 and no timer is synthesized.

Test Plan:
- Single request: reset, then req=4'b0010 at cycle 5 → eng_start high at cycle 7 with msg_id=1 and active=1 for 7..done. Drive eng_done at 12 → active=0 at 13.
- Priority: req 4'b1010 rising together → grants msg_id=1 first, then msg_id=3 after done. pending=4'b1000 during the first grant.
- Busy gating: eng_busy=1 while pending=4'b0001 → no eng_start. Drop busy at cycle 20 → eng_start at 21.
- Lost: req[2] toggles 0→1→0→1 during a grant to source 0 → lost=4'b0100 and pending[2]=1. clr_lost pulse → lost=0.
- Reset mid-grant: rst during WAIT with pending=4'b0100 → all outputs 0 next cycle. req[3] held high through reset → one grant with msg_id=3 afterwards.
- Timeout (PRINT_TIMEOUT_EN, TIMEOUT=8): no eng_done → timeout pulse after 8 WAIT cycles, state IDLE. Second run with done on the 8th cycle → timeout=0.
